// File: rtl/sw_debounce4.sv
// sw_debounce4 -- four-channel switch conditioner for the AND-chain gate stage.
//   Each raw switch is brought into clk through a two-flop synchroniser, then
//   debounced: a new level must persist for DEBOUNCE_CYCLES synchronised
//   cycles before it is committed to sw_out. A commit also fires a one-cycle
//   rise/fall pulse for that channel and a shared 'changed' strobe.
// Ports:
//   clk      system clock (rising edge)
//   rst      synchronous active-high reset
//   sw_in    raw asynchronous switch levels, bit0..3 -> gate a..d
//   sw_out   debounced levels (flop outputs only)
//   rise     1-cycle pulse per channel on a 0->1 commit
//   fall     1-cycle pulse per channel on a 1->0 commit
//   changed  1-cycle pulse when any channel commits

// Single debounce channel: synchroniser, hold counter, level and edge flops.
module sw_debounce4_lane #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic commit   // combinational: this edge commits a new level
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1, s2;
  logic [CNT_W-1:0] cnt;
  logic             diff;

  assign diff   = s2 ^ dout;
  // Commit on the edge where the level has already been seen N-1 times;
  // this edge is the Nth, so the counter never needs to reach N.
  assign commit = diff && (cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      cnt  <= '0;
      dout <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      rise <= commit & s2;
      fall <= commit & ~s2;
      if (commit) begin
        dout <= s2;
        cnt  <= '0;
      end else if (diff) begin
        cnt  <= cnt + 1'b1;
      end else begin
        // Level matches (or bounced back): abandon any pending change.
        cnt  <= '0;
      end
    end
  end
endmodule

module sw_debounce4 #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw_in,
  output logic [3:0] sw_out,
  output logic [3:0] rise,
  output logic [3:0] fall,
  output logic       changed
);
  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0] commit;

  genvar i;
  generate
    for (i = 0; i < NUM_LANES; i++) begin : g_lane
      sw_debounce4_lane #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
      ) u_lane (
        .clk   (clk),
        .rst   (rst),
        .din   (sw_in[i]),
        .dout  (sw_out[i]),
        .rise  (rise[i]),
        .fall  (fall[i]),
        .commit(commit[i])
      );
    end
  endgenerate

  // Registered from the same commit terms as rise/fall so it lines up with them.
  always_ff @(posedge clk) begin
    if (rst) changed <= 1'b0;
    else     changed <= |commit;
  end
endmodule

// File: tb/tb_sw_debounce4.sv
module tb_sw_debounce4;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sw_in = 4'hF;
  logic [3:0] sw_out, rise, fall;
  logic       changed;

  sw_debounce4 #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .sw_in  (sw_in),
    .sw_out (sw_out),
    .rise   (rise),
    .fall   (fall),
    .changed(changed)
  );

  always #5 clk = ~clk;

  // cyc equals the number of rising edges seen so far
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] out;
    logic [3:0] rise;
    logic [3:0] fall;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Inputs change just after the current edge, so the next edge is k;
  // commit lands on edge k+5 = current cyc + 6.
  task automatic push(logic [3:0] out, logic [3:0] r, logic [3:0] f);
    exp_t x;
    x.cyc = cyc + 6; x.out = out; x.rise = r; x.fall = f;
    q.push_back(x);
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && q.size() != 0; i++) step();
    chk("drain_timeout", q.size(), 0);
    step(); step();
  endtask

  // Monitor: 'changed' is the output strobe; pop and compare on it.
  always @(negedge clk) begin
    if (mon_en) begin
      if (changed === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_commit: sw_out=%b rise=%b fall=%b expected none (cyc %0d)",
                   sw_out, rise, fall, cyc);
        end else begin
          e = q.pop_front();
          chk("commit_cycle", cyc, e.cyc);
          chk("commit_sw_out", sw_out, e.out);
          chk("commit_rise", rise, e.rise);
          chk("commit_fall", fall, e.fall);
        end
      end else begin
        chk("idle_pulses", {rise, fall}, 8'h00);
      end
    end
  end

  initial begin
    // 1: reset with switches high
    rst = 1'b1; sw_in = 4'hF;
    step(); step();
    mon_en = 1;
    chk("reset_sw_out", sw_out, 4'h0);
    chk("reset_pulses", {rise, fall}, 8'h00);
    chk("reset_changed", changed, 1'b0);
    sw_in = 4'h0;
    step(); step();
    rst = 1'b0;
    step(); step();

    // 2: clean step on channel 0
    sw_in = 4'b0001;
    push(4'b0001, 4'b0001, 4'b0000);
    drain();

    // 3: bounce on channel 1, then a clean hold
    sw_in = 4'b0011; step(); step(); step();
    sw_in = 4'b0001; step();
    sw_in = 4'b0011; step(); step(); step();
    sw_in = 4'b0001; step(); step(); step(); step();
    chk("bounce_hold", sw_out, 4'b0001);
    sw_in = 4'b0011;
    push(4'b0011, 4'b0010, 4'b0000);
    drain();

    // 4: all channels rise together after a reset
    rst = 1'b1; sw_in = 4'h0;
    step(); step();
    chk("reset2_sw_out", sw_out, 4'h0);
    rst = 1'b0;
    sw_in = 4'hF;
    push(4'hF, 4'hF, 4'h0);
    drain();
    chk("and_g", &sw_out, 1'b1);

    // 5: channel 3 falls
    sw_in = 4'b0111;
    push(4'b0111, 4'b0000, 4'b1000);
    drain();
    chk("and_g_low", &sw_out, 1'b0);

    // 6: reset in the middle of a pending change
    rst = 1'b1; sw_in = 4'h0;
    step(); step();
    rst = 1'b0;
    step(); step();
    sw_in = 4'b0100;
    step(); step(); step();
    rst = 1'b1;
    step();
    chk("midreset_sw_out_a", sw_out, 4'h0);
    step();
    chk("midreset_sw_out_b", sw_out, 4'h0);
    rst = 1'b0;
    push(4'b0100, 4'b0100, 4'b0000);
    drain();
    for (int i = 0; i < 6; i++) step();
    chk("final_queue_empty", q.size(), 0);
    chk("final_sw_out", sw_out, 4'b0100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
